piso_tx: RTL and testbench
==========================

PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB shifted first.
REQ-003 clk  input  1  Single clock; all state updates on rising edge.
REQ-004 clear  input  1  Reset, asynchronous, active-high.
REQ-005 din  input  WIDTH  Parallel word to serialize.
REQ-006 load_valid  input  1  din valid; word transfers on the clk edge where load_valid && load_ready.
REQ-007 load_ready  output  1  Block can accept a word this cycle.
REQ-008 so  output  1  Serial data out.
REQ-009 so_valid  output  1  so carries a valid bit this cycle.
REQ-010 frame_start  output  1  High during the first bit of each word.
REQ-011 done  output  1  High during the last bit of each word.

Function
REQ-012 Internal state: shift register (WIDTH), bit counter (0..WIDTH-1), one-word hold buffer with full flag, FSM {IDLE, SHIFT}.
REQ-013 IDLE: load_ready=1, so_valid=0, so=0, frame_start=0, done=0.
REQ-014 IDLE + handshake at edge k: din -> shift register, counter=0, FSM -> SHIFT; bits appear on so in cycles k+1..k+WIDTH.
REQ-015 SHIFT: so_valid=1; so = shift register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0); register shifts one position per clk, vacated bit filled with 0; counter increments per clk.
REQ-016 frame_start=1 when SHIFT and counter==0; done=1 when SHIFT and counter==WIDTH-1; both otherwise 0.
REQ-017 SHIFT: load_ready = !hold_full; handshake while counter<WIDTH-1 stores din in hold buffer, hold_full=1.
REQ-018 Last-bit edge (counter==WIDTH-1), hold_full=1: hold -> shift register, hold_full=0, counter=0, stay SHIFT; no idle gap.
REQ-019 Last-bit edge, hold_full=0, handshake same cycle: din bypasses hold directly into shift register, counter=0, stay SHIFT; no idle gap.
REQ-020 Last-bit edge, hold_full=0, no handshake: FSM -> IDLE.
REQ-021 Handshake while hold_full=1 is impossible (load_ready=0); din/load_valid ignored whenever load_ready=0.
REQ-022 din contents, including X/Z, are irrelevant in any cycle without a handshake.
REQ-023 Output so is 0 whenever so_valid=0; no output changes except on clk edge or clear.

Reset
REQ-024 clear=1 forces immediately, without clk: FSM=IDLE, shift register=0, counter=0, hold_full=0, so=0, so_valid=0, frame_start=0, done=0, load_ready=1.
REQ-025 clear asserted mid-frame discards the frame in progress and the hold buffer; no residual bits emitted after release.
REQ-026 First handshake possible on the first rising edge with clear=0.

Verification
REQ-027 Reset: load 8'hFF, assert clear after 3 bits between edges -> so, so_valid drop to 0 at once; load_ready=1; no further bits after release.
REQ-028 Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 -> so = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start on bit 1, done on bit 8; so_valid=0 next cycle.
REQ-029 Back-to-back: 8'hA5 then 8'h3C held valid -> second accepted during bit 1 of first frame, load_ready=0 until first frame's last edge; 16 contiguous valid bits, frame_start on bits 1 and 9.
REQ-030 Bypass: load 8'h3C exactly on done cycle of prior frame with hold empty -> next frame starts on the next cycle, no gap.
REQ-031 MSB_FIRST=0, din=8'h01 -> so = 1 then seven 0s.
REQ-032 din=X with load_valid=0 in IDLE for 5 cycles -> so_valid stays 0, so=0, no X on any output.

Source files
------------

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in / serial-out transmitter with a one-word hold buffer.
//
// A word accepted on a load_valid && load_ready edge is shifted out one bit
// per clock, starting on the following cycle. While a word is shifting, one
// further word can be parked in the hold buffer. Back-to-back words therefore
// stream without an idle cycle between frames.
//
// Ports
//   clk          in   rising-edge clock for all state
//   clear        in   asynchronous active-high reset
//   din          in   [WIDTH] parallel word
//   load_valid   in   din valid
//   load_ready   out  block can accept a word this cycle
//   so           out  serial data (0 whenever so_valid is low)
//   so_valid     out  so carries a valid bit
//   frame_start  out  first bit of a word is on so
//   done         out  last bit of a word is on so
//
// state | meaning
// IDLE  | nothing to send; ready for a word, all serial outputs low
// SHIFT | a word is being shifted out; hold buffer may take the next word
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt, cnt_n;

  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_bit;

  // Vacated position is filled with 0 so a drained register reads all-zero.
  assign shifted  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign last_bit = (cnt == LAST);

  // All outputs decode registered state only, so they move on clk or clear.
  assign load_ready  = (state == IDLE) || !hold_full;
  assign so_valid    = (state == SHIFT);
  assign so          = so_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign frame_start = so_valid && (cnt == '0);
  assign done        = so_valid && last_bit;
  assign accept      = load_valid && load_ready;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    cnt_n       = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = din;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_n = shifted;
          cnt_n  = cnt + CW'(1);
          if (accept) begin
            hold_n      = din;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          // Parked word follows immediately; load_ready is low, so no
          // handshake can collide with this transfer.
          sreg_n      = hold;
          hold_full_n = 1'b0;
          cnt_n       = '0;
        end else if (accept) begin
          // Hold is empty: a word arriving on the last bit skips the buffer.
          sreg_n = din;
          cnt_n  = '0;
        end else begin
          sreg_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  logic       clk;
  logic       clear;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready, so, so_valid, frame_start, done;

  logic [7:0] din2;
  logic       load_valid2;
  logic       load_ready2, so2, so_valid2, frame_start2, done2;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .clear       (clear),
    .din         (din),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .so          (so),
    .so_valid    (so_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .clear       (clear),
    .din         (din2),
    .load_valid  (load_valid2),
    .load_ready  (load_ready2),
    .so          (so2),
    .so_valid    (so_valid2),
    .frame_start (frame_start2),
    .done        (done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " so"},          {31'd0, so},          32'd0);
    check({tag, " so_valid"},    {31'd0, so_valid},    32'd0);
    check({tag, " frame_start"}, {31'd0, frame_start}, 32'd0);
    check({tag, " done"},        {31'd0, done},        32'd0);
    check({tag, " load_ready"},  {31'd0, load_ready},  32'd1);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] stream;

    clear       = 1'b1;
    din         = '0;
    load_valid  = 1'b0;
    din2        = '0;
    load_valid2 = 1'b0;

    // reset state, before any clock edge
    #2;
    check_idle("reset");
    check("reset lsb so_valid", {31'd0, so_valid2}, 32'd0);
    check("reset lsb load_ready", {31'd0, load_ready2}, 32'd1);
    tick();
    clear = 1'b0;

    // X on din without load_valid while idle
    din = 'x;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("x_idle");
    end

    // single word A5, MSB first
    w = 8'hA5;
    din = w; load_valid = 1'b1;
    tick();
    din = 'x; load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("single so", {31'd0, so}, {31'd0, w[7-i]});
      check("single so_valid", {31'd0, so_valid}, 32'd1);
      check("single frame_start", {31'd0, frame_start}, {31'd0, (i == 0)});
      check("single done", {31'd0, done}, {31'd0, (i == 7)});
      check("single load_ready", {31'd0, load_ready}, 32'd1);
      tick();
    end
    check_idle("single after");

    // back-to-back: A5 then 3C parked in hold buffer
    stream = 16'hA53C;
    din = 8'hA5; load_valid = 1'b1;
    tick();
    din = 8'h3C; load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("b2b so", {31'd0, so}, {31'd0, stream[15-i]});
      check("b2b so_valid", {31'd0, so_valid}, 32'd1);
      check("b2b frame_start", {31'd0, frame_start}, {31'd0, (i == 0 || i == 8)});
      check("b2b done", {31'd0, done}, {31'd0, (i == 7 || i == 15)});
      check("b2b load_ready", {31'd0, load_ready}, {31'd0, (i == 0 || i >= 8)});
      if (i == 1) begin
        din = 'x; load_valid = 1'b0;
      end
      tick();
    end
    check_idle("b2b after");

    // bypass: 3C offered exactly on the done cycle with hold empty
    din = 8'hA5; load_valid = 1'b1;
    tick();
    din = 'x; load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("bypass so", {31'd0, so}, {31'd0, stream[15-i]});
      check("bypass so_valid", {31'd0, so_valid}, 32'd1);
      check("bypass frame_start", {31'd0, frame_start}, {31'd0, (i == 0 || i == 8)});
      check("bypass done", {31'd0, done}, {31'd0, (i == 7 || i == 15)});
      check("bypass load_ready", {31'd0, load_ready}, 32'd1);
      if (i == 7) begin
        din = 8'h3C; load_valid = 1'b1;
      end else begin
        din = 'x; load_valid = 1'b0;
      end
      tick();
    end
    check_idle("bypass after");

    // clear mid-frame, between edges, with a word parked in the hold buffer
    din = 8'hFF; load_valid = 1'b1;
    tick();
    din = 8'h81; load_valid = 1'b1;
    tick();
    din = 'x; load_valid = 1'b0;
    tick();
    check("pre_clear so", {31'd0, so}, 32'd1);
    check("pre_clear load_ready", {31'd0, load_ready}, 32'd0);
    #2;
    clear = 1'b1;
    #1;
    check_idle("clear async");
    #1;
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_clear so", {31'd0, so}, 32'd0);
      check("post_clear so_valid", {31'd0, so_valid}, 32'd0);
    end
    check_idle("post_clear");

    // LSB-first instance, din = 01
    w = 8'h01;
    din2 = w; load_valid2 = 1'b1;
    tick();
    din2 = 'x; load_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb so", {31'd0, so2}, {31'd0, w[i]});
      check("lsb so_valid", {31'd0, so_valid2}, 32'd1);
      check("lsb frame_start", {31'd0, frame_start2}, {31'd0, (i == 0)});
      check("lsb done", {31'd0, done2}, {31'd0, (i == 7)});
      tick();
    end
    check("lsb after so_valid", {31'd0, so_valid2}, 32'd0);
    check("lsb after so", {31'd0, so2}, 32'd0);

    // LSB-first with a non-palindromic word
    w = 8'hB2;
    din2 = w; load_valid2 = 1'b1;
    tick();
    din2 = 'x; load_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb2 so", {31'd0, so2}, {31'd0, w[i]});
      tick();
    end
    check("lsb2 after so_valid", {31'd0, so_valid2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
